tlul_sram_arb: RTL and testbench
================================

TLUL_SRAM_ARB -- requirements
Module: tlul_sram_arb

Interface
REQ-001 Parameter: MaxCoreStreak, default 4, meaning consecutive contended core wins allowed before main is forced a grant (range 1..15).
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 tl_core_i  input  tlul_pkg::tl_h2d_t  requests from core-side host.
REQ-005 tl_core_o  output  tlul_pkg::tl_d2h_t  responses to core-side host.
REQ-006 tl_main_i  input  tlul_pkg::tl_h2d_t  requests from main-crossbar host.
REQ-007 tl_main_o  output  tlul_pkg::tl_d2h_t  responses to main-crossbar host.
REQ-008 tl_sram_o  output  tlul_pkg::tl_h2d_t  request to shared SRAM device.
REQ-009 tl_sram_i  input  tlul_pkg::tl_d2h_t  response from shared SRAM device.
REQ-010 busy_o  output  1  high while a transaction is in ISSUE or WAIT_D.
REQ-011 owner_o  output  1  current/last grant owner: 0 = core, 1 = main.
REQ-012 spurious_rsp_o  output  1  one-cycle pulse when the device presents d_valid in IDLE.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT_D; exactly one transaction is outstanding at a time.
REQ-014 IDLE: on any host a_valid, latch winner into owner and move to ISSUE next cycle; no a_valid -> stay IDLE.
REQ-015 Arbitration: core wins by default; main wins if only main requests, or both request and streak counter equals MaxCoreStreak.
REQ-016 Streak counter: +1 on each core grant while main a_valid was also high; cleared on any main grant; saturates at MaxCoreStreak.
REQ-017 ISSUE: tl_sram_o A fields and a_valid driven from owner's tl_*_i; owner's a_ready = tl_sram_i.a_ready; non-owner a_ready = 0.
REQ-018 ISSUE -> WAIT_D on cycle where tl_sram_o.a_valid and tl_sram_i.a_ready both high.
REQ-019 WAIT_D: tl_sram_i D fields and d_valid routed to owner; tl_sram_o.d_ready = owner's d_ready; non-owner d_valid = 0.
REQ-020 WAIT_D -> IDLE on d_valid and d_ready both high; next arbitration occurs in that IDLE cycle (minimum 3 cycles per transaction).
REQ-021 A-to-device latency: host a_valid in cycle N -> tl_sram_o.a_valid in cycle N+1 at earliest.
REQ-022 IDLE/WAIT_D: tl_sram_o.a_valid = 0; IDLE/ISSUE: both hosts' d_valid = 0, tl_sram_o.d_ready = 1 in IDLE only (drain spurious response).
REQ-023 d_valid in IDLE: discarded, spurious_rsp_o pulses for that cycle, FSM unchanged.
REQ-024 Response same cycle as A handshake (d_valid while still in ISSUE) is not accepted until WAIT_D; device holds it per TL-UL.
REQ-025 Host dropping a_valid in ISSUE before handshake: protocol violation, behaviour unspecified, covered by assertion only.
REQ-026 All non-routed A/D payload outputs driven to zero when not valid.

Reset
REQ-027 rst_ni low at a clock edge: state = IDLE, owner = 0, streak = 0, busy_o = 0, spurious_rsp_o = 0, all valids = 0, all a_ready = 0.
REQ-028 Reset mid-transaction abandons it; no response is forwarded after reset release; a late device response is treated per REQ-023.

Structure
REQ-029 FSM state enum and owner encoding reside in a shared package tlul_sram_arb_pkg.
REQ-030 Arbitration decision with streak counter is one sub-module, tlul_sram_arb_rr, instantiated once.
REQ-031 No TL-UL integrity regeneration; payload passes unmodified.

Verification
REQ-032 Core read addr 0x100 alone, device a_ready=1, d_valid 1 cycle later -> tl_sram_o.a_valid cycle N+1, core receives d_data, busy_o low cycle N+4.
REQ-033 Both hosts request continuously, MaxCoreStreak=4 -> grant order C,C,C,C,M,C,C,C,C,M.
REQ-034 Main write 0xDEADBEEF to 0x40 with device a_ready held low 5 cycles -> state stays ISSUE, core a_ready=0 throughout, write completes after stall.
REQ-035 Device d_valid asserted in IDLE -> spurious_rsp_o single-cycle pulse, no host d_valid.
REQ-036 rst_ni low for 1 cycle during WAIT_D -> all outputs at reset values next cycle, pending response never reaches the host.
REQ-037 Owner d_ready low 3 cycles in WAIT_D -> tl_sram_o.d_ready low, FSM holds, completes on d_ready.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel definitions shared by the SRAM arbiter slice.
// tl_h2d_t : host-to-device A channel plus the host's D-channel ready.
// tl_d2h_t : device-to-host D channel plus the device's A-channel ready.
package tlul_pkg;

    localparam logic [2:0] PUT_FULL_DATA   = 3'h0;
    localparam logic [2:0] GET             = 3'h4;
    localparam logic [2:0] ACCESS_ACK      = 3'h0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_sram_arb_pkg.sv
// Shared types for the two-host SRAM arbiter: FSM state encoding, grant
// owner encoding and the width of the core-streak budget counter.
package tlul_sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_MAIN = 1'b1
    } owner_e;

    // Holds MaxCoreStreak up to 15.
    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/tlul_sram_arb_rr.sv
// Grant decision for the SRAM arbiter.
// Ports:
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   req_core, req_main   : a_valid of each host
//   grant_en             : a grant is being taken this cycle (IDLE with a request)
//   winner               : host that wins if grant_en is high
// Core wins by default. Fairness is tracked as a down-counting budget of
// contended core wins left; when it reaches zero a contending main wins and
// the budget reloads. Budget at terminal count is the same condition as
// "streak equals MaxCoreStreak".
module tlul_sram_arb_rr
    import tlul_sram_arb_pkg::*;
#(
    parameter int unsigned MaxCoreStreak = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   req_core,
    input  logic   req_main,
    input  logic   grant_en,
    output owner_e winner
);

    localparam logic [STREAK_W-1:0] CreditMax = STREAK_W'(MaxCoreStreak);

    logic [STREAK_W-1:0] credit_q;

    assign winner = (req_main && (!req_core || credit_q == '0)) ? OWNER_MAIN : OWNER_CORE;

    // Budget never underflows: at zero a contending main always wins.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credit_q <= CreditMax;
        end else if (grant_en) begin
            if (winner == OWNER_MAIN) begin
                credit_q <= CreditMax;
            end else if (req_main) begin
                credit_q <= credit_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlul_sram_arb.sv
// Two-host TL-UL arbiter in front of a single shared SRAM device, one
// transaction outstanding at a time.
// Ports:
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   tl_core_i/_o     : core-side host request / response
//   tl_main_i/_o     : main-crossbar host request / response
//   tl_sram_o/_i     : request to / response from the shared SRAM
//   busy_o           : transaction in ISSUE or WAIT_D
//   owner_o          : current/last grant owner (0 core, 1 main)
//   spurious_rsp_o   : device presented d_valid while IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate, drain any stray device response
// ST_ISSUE  | owner's A request forwarded to the device until accepted
// ST_WAIT_D | waiting for the device response, routed to the owner
module tlul_sram_arb
    import tlul_pkg::*;
    import tlul_sram_arb_pkg::*;
#(
    parameter int unsigned MaxCoreStreak = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_core_i,
    output tl_d2h_t tl_core_o,
    input  tl_h2d_t tl_main_i,
    output tl_d2h_t tl_main_o,
    output tl_h2d_t tl_sram_o,
    input  tl_d2h_t tl_sram_i,
    output logic    busy_o,
    output logic    owner_o,
    output logic    spurious_rsp_o
);

    arb_state_e state_q, state_d;
    owner_e     owner_q, winner;
    logic       any_req, grant_en;
    tl_h2d_t    owner_req;
    tl_d2h_t    owner_rsp;

    assign any_req   = tl_core_i.a_valid | tl_main_i.a_valid;
    assign grant_en  = (state_q == ST_IDLE) && any_req;
    assign owner_req = (owner_q == OWNER_MAIN) ? tl_main_i : tl_core_i;
    assign owner_o   = owner_q;

    tlul_sram_arb_rr #(
        .MaxCoreStreak (MaxCoreStreak)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_core (tl_core_i.a_valid),
        .req_main (tl_main_i.a_valid),
        .grant_en (grant_en),
        .winner   (winner)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_CORE;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                owner_q <= winner;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_ISSUE;
            ST_ISSUE:  if (owner_req.a_valid && tl_sram_i.a_ready) state_d = ST_WAIT_D;
            ST_WAIT_D: if (tl_sram_i.d_valid && owner_req.d_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Device D payload reaches the owner only alongside d_valid; its a_ready
    // never leaks through in WAIT_D.
    always_comb begin
        owner_rsp = '0;
        if (tl_sram_i.d_valid) begin
            owner_rsp         = tl_sram_i;
            owner_rsp.a_ready = 1'b0;
        end
    end

    always_comb begin
        tl_sram_o      = '0;
        tl_core_o      = '0;
        tl_main_o      = '0;
        busy_o         = 1'b0;
        spurious_rsp_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Accept and drop anything the device offers with no owner.
                tl_sram_o.d_ready = 1'b1;
                spurious_rsp_o    = tl_sram_i.d_valid & rst_ni;
            end
            ST_ISSUE: begin
                busy_o = 1'b1;
                if (owner_req.a_valid) begin
                    tl_sram_o         = owner_req;
                    tl_sram_o.d_ready = 1'b0;
                end
                if (owner_q == OWNER_MAIN) tl_main_o.a_ready = tl_sram_i.a_ready;
                else                       tl_core_o.a_ready = tl_sram_i.a_ready;
            end
            ST_WAIT_D: begin
                busy_o            = 1'b1;
                tl_sram_o.d_ready = owner_req.d_ready;
                if (owner_q == OWNER_MAIN) tl_main_o = owner_rsp;
                else                       tl_core_o = owner_rsp;
            end
            default: ;
        endcase
    end

    // A host must hold its request until the device has accepted it.
    a_valid_held_in_issue: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_ISSUE) |-> owner_req.a_valid
    );

endmodule

// File: tb/tb_tlul_sram_arb.sv
module tb_tlul_sram_arb;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tl_h2d_t host_h2d [2];
    tl_d2h_t host_d2h [2];
    tl_h2d_t sram_h2d;
    tl_d2h_t sram_d2h;
    logic    busy, owner, spurious;

    tlul_sram_arb #(.MaxCoreStreak(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tl_core_i      (host_h2d[0]),
        .tl_core_o      (host_d2h[0]),
        .tl_main_i      (host_h2d[1]),
        .tl_main_o      (host_d2h[1]),
        .tl_sram_o      (sram_h2d),
        .tl_sram_i      (sram_d2h),
        .busy_o         (busy),
        .owner_o        (owner),
        .spurious_rsp_o (spurious)
    );

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { logic [2:0] opcode; logic [7:0] source; logic [31:0] data; } exp_t;

    req_t req_q [2][$];
    exp_t exp_q [2][$];
    logic active [2];
    logic a_hs [2];
    logic d_rdy [2];
    logic [7:0] seq [2];

    int   dev_stall, dev_lat, dev_cnt;
    logic dev_has_rsp, dev_spur;
    exp_t dev_rsp;
    logic [31:0] last_wr_addr, last_wr_data;
    logic grant_log [$];

    logic s_sram_a_valid, s_sram_d_valid, s_sram_d_ready, s_busy, s_owner, s_spur;
    logic [31:0] s_sram_addr;
    logic s_a_ready [2];
    logic s_d_valid [2];
    logic s_d_hs [2];
    int   spur_cnt, core_dv_cnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] addr);
        return {addr[15:0], 16'h0} ^ 32'h5A5A_C3C3 ^ addr;
    endfunction

    task automatic push_req(input int h, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
        req_t r;
        r.we = we; r.addr = addr; r.data = data;
        req_q[h].push_back(r);
    endtask

    // One clock cycle: hosts drive, device drives, then sample and score.
    task automatic step();
        req_t r;
        exp_t e;
        @(posedge clk); #1;
        for (int h = 0; h < 2; h++) begin
            if (active[h] && a_hs[h]) active[h] = 1'b0;
            if (!active[h] && req_q[h].size() > 0) begin
                r = req_q[h].pop_front();
                host_h2d[h]           = '0;
                host_h2d[h].a_valid   = 1'b1;
                host_h2d[h].a_opcode  = r.we ? PUT_FULL_DATA : GET;
                host_h2d[h].a_size    = 2'd2;
                host_h2d[h].a_source  = 8'(16 * (h + 1)) + seq[h];
                host_h2d[h].a_address = r.addr;
                host_h2d[h].a_mask    = 4'hF;
                host_h2d[h].a_data    = r.we ? r.data : 32'h0;
                e.opcode = r.we ? ACCESS_ACK : ACCESS_ACK_DATA;
                e.source = host_h2d[h].a_source;
                e.data   = r.we ? 32'h0 : rd_fn(r.addr);
                exp_q[h].push_back(e);
                seq[h]    = seq[h] + 8'd1;
                active[h] = 1'b1;
            end else if (!active[h]) begin
                host_h2d[h] = '0;
            end
            host_h2d[h].d_ready = d_rdy[h];
        end
        #1;
        sram_d2h         = '0;
        sram_d2h.a_ready = (dev_stall == 0);
        if (dev_has_rsp) begin
            if (dev_cnt > 0) dev_cnt--;
            if (dev_cnt == 0) begin
                sram_d2h.d_valid  = 1'b1;
                sram_d2h.d_opcode = dev_rsp.opcode;
                sram_d2h.d_size   = 2'd2;
                sram_d2h.d_source = dev_rsp.source;
                sram_d2h.d_data   = dev_rsp.data;
            end
        end else if (dev_spur) begin
            sram_d2h.d_valid  = 1'b1;
            sram_d2h.d_opcode = ACCESS_ACK_DATA;
            sram_d2h.d_data   = 32'hBAD0_0BAD;
        end
        @(negedge clk);
        for (int h = 0; h < 2; h++) begin
            a_hs[h]      = host_h2d[h].a_valid && host_d2h[h].a_ready;
            s_a_ready[h] = host_d2h[h].a_ready;
            s_d_valid[h] = host_d2h[h].d_valid;
            s_d_hs[h]    = host_d2h[h].d_valid && host_h2d[h].d_ready;
            if (s_d_hs[h]) begin
                if (exp_q[h].size() == 0) begin
                    chk($sformatf("unexpected_rsp_h%0d", h), 32'(s_d_hs[h]), 32'h0);
                end else begin
                    e = exp_q[h].pop_front();
                    chk($sformatf("d_opcode_h%0d", h), 32'(host_d2h[h].d_opcode), 32'(e.opcode));
                    chk($sformatf("d_source_h%0d", h), 32'(host_d2h[h].d_source), 32'(e.source));
                    chk($sformatf("d_data_h%0d", h), host_d2h[h].d_data, e.data);
                end
            end
        end
        s_sram_a_valid = sram_h2d.a_valid;
        s_sram_addr    = sram_h2d.a_address;
        s_sram_d_valid = sram_d2h.d_valid;
        s_sram_d_ready = sram_h2d.d_ready;
        s_busy         = busy;
        s_owner        = owner;
        s_spur         = spurious;
        if (spurious) spur_cnt++;
        if (host_d2h[0].d_valid) core_dv_cnt++;
        if (sram_d2h.d_valid && sram_h2d.d_ready && dev_has_rsp) dev_has_rsp = 1'b0;
        if (sram_h2d.a_valid && sram_d2h.a_ready) begin
            grant_log.push_back(owner);
            dev_has_rsp    = 1'b1;
            dev_cnt        = dev_lat + 1;
            dev_rsp.source = sram_h2d.a_source;
            if (sram_h2d.a_opcode == GET) begin
                dev_rsp.opcode = ACCESS_ACK_DATA;
                dev_rsp.data   = rd_fn(sram_h2d.a_address);
            end else begin
                dev_rsp.opcode = ACCESS_ACK;
                dev_rsp.data   = 32'h0;
                last_wr_addr   = sram_h2d.a_address;
                last_wr_data   = sram_h2d.a_data;
            end
        end else if (sram_h2d.a_valid && dev_stall > 0) begin
            dev_stall--;
        end
    endtask

    task automatic clear_hosts();
        for (int h = 0; h < 2; h++) begin
            req_q[h].delete();
            exp_q[h].delete();
            active[h] = 1'b0;
            a_hs[h]   = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clear_hosts();
    endtask

    task automatic drain(input string tag);
        int left;
        for (int cyc = 0; cyc < 400; cyc++) begin
            left = exp_q[0].size() + exp_q[1].size() + req_q[0].size() + req_q[1].size();
            if (left == 0) break;
            step();
        end
        left = exp_q[0].size() + exp_q[1].size() + req_q[0].size() + req_q[1].size();
        chk(tag, 32'(left), 32'h0);
    endtask

    initial begin
        logic [9:0] exp_order;
        int cyc;
        rst_n        = 1'b0;
        host_h2d[0]  = '0;
        host_h2d[1]  = '0;
        sram_d2h     = '0;
        d_rdy[0]     = 1'b1;
        d_rdy[1]     = 1'b1;
        seq[0]       = 8'd0;
        seq[1]       = 8'd0;
        dev_stall    = 0;
        dev_lat      = 1;
        dev_cnt      = 0;
        dev_has_rsp  = 1'b0;
        dev_spur     = 1'b0;
        last_wr_addr = 32'h0;
        last_wr_data = 32'h0;
        spur_cnt     = 0;
        core_dv_cnt  = 0;
        clear_hosts();
        do_reset();

        // Reset values
        chk("rst_busy", 32'(s_busy), 32'h0);
        chk("rst_owner", 32'(s_owner), 32'h0);
        chk("rst_sram_a_valid", 32'(s_sram_a_valid), 32'h0);
        chk("rst_core_a_ready", 32'(s_a_ready[0]), 32'h0);
        chk("rst_main_a_ready", 32'(s_a_ready[1]), 32'h0);
        chk("rst_core_d_valid", 32'(s_d_valid[0]), 32'h0);
        chk("rst_main_d_valid", 32'(s_d_valid[1]), 32'h0);
        chk("rst_spurious", 32'(s_spur), 32'h0);
        chk("rst_idle_d_ready", 32'(s_sram_d_ready), 32'h1);

        // Single core read, latency profile
        push_req(0, 1'b0, 32'h100, 32'h0);
        step();
        chk("lat_n_a_valid", 32'(s_sram_a_valid), 32'h0);
        chk("lat_n_busy", 32'(s_busy), 32'h0);
        step();
        chk("lat_n1_a_valid", 32'(s_sram_a_valid), 32'h1);
        chk("lat_n1_addr", s_sram_addr, 32'h100);
        chk("lat_n1_owner", 32'(s_owner), 32'h0);
        step();
        chk("lat_n2_busy", 32'(s_busy), 32'h1);
        chk("lat_n2_core_d_valid", 32'(s_d_valid[0]), 32'h0);
        step();
        chk("lat_n3_core_d_hs", 32'(s_d_hs[0]), 32'h1);
        chk("lat_n3_busy", 32'(s_busy), 32'h1);
        step();
        chk("lat_n4_busy", 32'(s_busy), 32'h0);

        // Continuous contention: C,C,C,C,M,C,C,C,C,M
        do_reset();
        grant_log.delete();
        for (int i = 0; i < 10; i++) begin
            push_req(0, 1'b0, 32'h200 + 32'(4 * i), 32'h0);
            push_req(1, 1'b0, 32'h300 + 32'(4 * i), 32'h0);
        end
        for (cyc = 0; cyc < 200 && grant_log.size() < 10; cyc++) step();
        chk("grant_count", 32'(grant_log.size() >= 10), 32'h1);
        exp_order = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            if (i < grant_log.size())
                chk($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        end
        drain("drain_contention");

        // Main write under device a_ready stall, core requesting meanwhile
        dev_stall = 5;
        push_req(1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        step();
        push_req(0, 1'b0, 32'h500, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_busy", 32'(s_busy), 32'h1);
            chk("stall_owner", 32'(s_owner), 32'h1);
            chk("stall_core_a_ready", 32'(s_a_ready[0]), 32'h0);
            chk("stall_main_a_ready", 32'(s_a_ready[1]), 32'h0);
        end
        step();
        chk("stall_release_main_a_ready", 32'(s_a_ready[1]), 32'h1);
        chk("stall_core_a_ready_rel", 32'(s_a_ready[0]), 32'h0);
        chk("wr_addr", last_wr_addr, 32'h40);
        chk("wr_data", last_wr_data, 32'hDEAD_BEEF);
        drain("drain_write");

        // Spurious device response while idle
        dev_spur = 1'b1;
        step();
        dev_spur = 1'b0;
        chk("spur_pulse", 32'(s_spur), 32'h1);
        chk("spur_core_d_valid", 32'(s_d_valid[0]), 32'h0);
        chk("spur_main_d_valid", 32'(s_d_valid[1]), 32'h0);
        chk("spur_busy", 32'(s_busy), 32'h0);
        step();
        chk("spur_clear", 32'(s_spur), 32'h0);

        // Reset while waiting for a response
        dev_lat = 6;
        push_req(0, 1'b0, 32'h600, 32'h0);
        for (cyc = 0; cyc < 20 && !dev_has_rsp; cyc++) step();
        step();
        chk("pre_rst_busy", 32'(s_busy), 32'h1);
        rst_n       = 1'b0;
        spur_cnt    = 0;
        core_dv_cnt = 0;
        step();
        rst_n = 1'b1;
        clear_hosts();
        chk("mid_rst_busy", 32'(s_busy), 32'h0);
        chk("mid_rst_owner", 32'(s_owner), 32'h0);
        chk("mid_rst_sram_a_valid", 32'(s_sram_a_valid), 32'h0);
        chk("mid_rst_core_d_valid", 32'(s_d_valid[0]), 32'h0);
        chk("mid_rst_core_a_ready", 32'(s_a_ready[0]), 32'h0);
        chk("mid_rst_spurious", 32'(s_spur), 32'h0);
        for (int i = 0; i < 10; i++) step();
        chk("rst_no_core_rsp", 32'(core_dv_cnt), 32'h0);
        chk("rst_late_spur", 32'(spur_cnt), 32'h1);
        chk("rst_dev_drained", 32'(dev_has_rsp), 32'h0);

        // Owner holds d_ready low for 3 cycles
        dev_lat  = 1;
        d_rdy[0] = 1'b0;
        push_req(0, 1'b0, 32'h700, 32'h0);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!s_sram_d_valid && cyc < 20);
        chk("dhold_seen", 32'(s_sram_d_valid), 32'h1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            chk("dhold_sram_d_ready", 32'(s_sram_d_ready), 32'h0);
            chk("dhold_busy", 32'(s_busy), 32'h1);
            chk("dhold_core_d_valid", 32'(s_d_valid[0]), 32'h1);
        end
        d_rdy[0] = 1'b1;
        step();
        chk("dhold_done", 32'(s_d_hs[0]), 32'h1);
        step();
        chk("dhold_idle", 32'(s_busy), 32'h0);

        chk("leftover_core", 32'(exp_q[0].size()), 32'h0);
        chk("leftover_main", 32'(exp_q[1].size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
